bip_alu_datapath: RTL
=====================

Name: bip_alu_datapath

Overview:
- Parametrised next-generation accumulator datapath for the BIP processor.
- Accumulator with sign-extended immediate, memory/immediate operand select and an 8-operation ALU.
- Adds Z/N/C status flags, a valid qualifier and an optional iterative multiplier with a busy/done handshake.
- Sits between the control unit (select/op signals, operand field) and the data memory (read data in, accumulator out).

Parameters:
- NB_DATA, 16, accumulator/data width; must be >= NB_OPERAND and >= 2.
- NB_OPERAND, 11, instruction operand field width; sign-extended to NB_DATA.
- NB_ALU_OP, 3, ALU opcode width; fixed encoding below.

Ports:
- i_clock  in  1  system clock; all state is on its rising edge.
- i_reset  in  1  asynchronous, active-low reset.
- i_valid  in  1  qualifies the control inputs for this cycle.
- i_operand  in  NB_OPERAND  immediate field from the control unit.
- i_data_mem  in  NB_DATA  data memory read data.
- i_sel_a  in  2  accumulator source: 00 mem, 01 sign-extended operand, 10 ALU, 11 hold.
- i_sel_b  in  1  ALU B operand: 0 i_data_mem, 1 sign-extended operand.
- i_wr_acc  in  1  accumulator write enable.
- i_alu_op  in  NB_ALU_OP  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL1, 110 SRA1, 111 MUL.
- o_data  out  NB_DATA  accumulator value (registered).
- o_zero  out  1  Z flag.
- o_neg  out  1  N flag.
- o_carry  out  1  C flag.
- o_busy  out  1  multiplier in progress.
- o_done  out  1  one-cycle pulse when the multiplier writes its result.

Behaviour:
- Reset (i_reset=0, asynchronous): acc=0, Z=N=C=0, o_busy=0, o_done=0, FSM=IDLE. Applies at any time, including mid-multiply; the aborted multiply produces no o_done.
- ext = i_operand sign-extended from bit NB_OPERAND-1; B = i_sel_b ? ext : i_data_mem.
- Write condition: i_valid & i_wr_acc & ~o_busy & (i_sel_a != 11). Otherwise acc and flags hold.
- sel_a=00/01 (load): acc <= mem/ext; Z,N from the new value; C unchanged. Single cycle.
- sel_a=10, single-cycle ops: result is written to acc at the next edge; Z = result==0; N = result MSB.
  - ADD: C = unsigned carry-out.
  - SUB (acc-B): C = borrow (acc < B, unsigned).
  - AND/OR/XOR: C unchanged.
  - SHL1: C = old acc MSB.
  - SRA1: C = old acc LSB, MSB replicated.
  - B is ignored for the shifts.
- Arithmetic wraps modulo 2^NB_DATA.
- MUL FSM, states IDLE -> MUL -> IDLE:
  - Accept in IDLE when the write condition holds with sel_a=10 and op=111. At the accept edge: latch acc and B unsigned, counter=0, o_busy=1.
  - Shift-add one multiplier bit per edge; exactly NB_DATA iterations.
  - On the final iteration edge: acc <= low NB_DATA bits of product; Z,N from the result; C = (high half != 0); o_busy=0; o_done=1 for one cycle; FSM back to IDLE.
  - o_busy is high for exactly NB_DATA cycles. All control inputs are ignored while busy, and a new op may be accepted on the cycle o_done is high.

Optional Feature:
- Macro BIP_DP_MUL_EN.
- Defined: MUL FSM, o_busy and o_done behave as above.
- Undefined:
  - No multiplier logic.
  - op 111 is a no-op: acc and flags hold.
  - o_busy and o_done are tied to 0.

Test Plan:
- Reset low mid-stream -> o_data=16'h0000, Z=N=C=0, o_busy=0, independent of the clock.
- Load operand 11'h7FF (sel_a=01) -> acc=16'hFFFF, N=1, Z=0; then ADD mem 16'h0001 -> acc=16'h0000, Z=1, C=1.
- acc=3, SUB immediate 5 -> acc=16'hFFFE, N=1, C=1; then i_valid=0 with i_wr_acc=1 -> acc unchanged.
- acc=16'h8001, SRA1 -> acc=16'hC000, C=1; then SHL1 -> acc=16'h8000, C=1, N=1.
- (BIP_DP_MUL_EN) acc=300, MUL immediate 250 -> o_busy high 16 cycles; acc=16'h24F8 (75000 mod 65536) with one-cycle o_done, C=1; ADD strobes during busy ignored.
- (BIP_DP_MUL_EN) reset asserted after 8 MUL iterations -> acc=0, o_busy=0, no o_done; without the macro, MUL leaves acc and flags unchanged.

Source files
------------

// File: rtl/bip_alu_datapath_if.sv
// Control-unit / data-memory bundle for bip_alu_datapath (selects, opcode, operand, memory data in; accumulator, flags, multiplier handshake out).
// Latency: none; wires only.
// Backpressure: no ready path; o_busy tells the control unit that the datapath is ignoring its inputs.
interface bip_alu_datapath_if #(
    parameter int NB_DATA    = 16,
    parameter int NB_OPERAND = 11,
    parameter int NB_ALU_OP  = 3
);
    logic                  i_valid;
    logic [NB_OPERAND-1:0] i_operand;
    logic [NB_DATA-1:0]    i_data_mem;
    logic [1:0]            i_sel_a;
    logic                  i_sel_b;
    logic                  i_wr_acc;
    logic [NB_ALU_OP-1:0]  i_alu_op;
    logic [NB_DATA-1:0]    o_data;
    logic                  o_zero;
    logic                  o_neg;
    logic                  o_carry;
    logic                  o_busy;
    logic                  o_done;

    // Control unit and data memory side
    modport master (
        output i_valid, i_operand, i_data_mem, i_sel_a, i_sel_b, i_wr_acc, i_alu_op,
        input  o_data, o_zero, o_neg, o_carry, o_busy, o_done
    );

    // Datapath side
    modport slave (
        input  i_valid, i_operand, i_data_mem, i_sel_a, i_sel_b, i_wr_acc, i_alu_op,
        output o_data, o_zero, o_neg, o_carry, o_busy, o_done
    );
endinterface

// File: rtl/bip_alu_datapath.sv
// BIP accumulator datapath: sign-extended immediate, mem/imm operand select, 8-op ALU, Z/N/C flags, optional MUL.
// Latency: loads and single-cycle ALU ops land at the next edge; MUL writes after NB_DATA busy cycles (o_done pulse).
// Backpressure: while o_busy is high all control inputs are ignored. Define BIP_DP_MUL_EN to build the multiplier.
module bip_alu_datapath #(
    parameter int NB_DATA    = 16,
    parameter int NB_OPERAND = 11,
    parameter int NB_ALU_OP  = 3
) (
    input  logic              i_clock,
    input  logic              i_reset,
    bip_alu_datapath_if.slave bus
);

    localparam logic [NB_ALU_OP-1:0] OP_ADD  = NB_ALU_OP'(0);
    localparam logic [NB_ALU_OP-1:0] OP_SUB  = NB_ALU_OP'(1);
    localparam logic [NB_ALU_OP-1:0] OP_AND  = NB_ALU_OP'(2);
    localparam logic [NB_ALU_OP-1:0] OP_OR   = NB_ALU_OP'(3);
    localparam logic [NB_ALU_OP-1:0] OP_XOR  = NB_ALU_OP'(4);
    localparam logic [NB_ALU_OP-1:0] OP_SHL1 = NB_ALU_OP'(5);
    localparam logic [NB_ALU_OP-1:0] OP_SRA1 = NB_ALU_OP'(6);

    // Architectural state
    logic [NB_DATA-1:0] acc_q, acc_d;
    logic               z_q, z_d;
    logic               n_q, n_d;
    logic               c_q, c_d;

    // Operand path and ALU results
    logic [NB_DATA-1:0] ext;
    logic [NB_DATA-1:0] b_opnd;
    logic [NB_DATA:0]   add_w;
    logic [NB_DATA:0]   sub_w;
    logic [NB_DATA-1:0] alu_res;
    logic               alu_c;
    logic               alu_wr;
    logic               busy;
    logic               wr_cond;
    logic               upd_zn;

`ifdef BIP_DP_MUL_EN
    localparam int                CNT_W    = $clog2(NB_DATA);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(NB_DATA - 1);

    typedef enum logic {
        ST_IDLE,
        ST_MUL
    } state_t;

    state_t               state_q, state_d;
    logic [2*NB_DATA-1:0] mcand_q, mcand_d;
    logic [NB_DATA-1:0]   mplier_q, mplier_d;
    logic [2*NB_DATA-1:0] prod_q, prod_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 done_q, done_d;

    assign busy = (state_q == ST_MUL);
`else
    assign busy = 1'b0;
`endif

    // Sign-extend the immediate field from its top bit
    always_comb begin
        ext                   = {NB_DATA{bus.i_operand[NB_OPERAND-1]}};
        ext[NB_OPERAND-1:0]   = bus.i_operand;
    end

    assign b_opnd  = bus.i_sel_b ? ext : bus.i_data_mem;
    assign add_w   = {1'b0, acc_q} + {1'b0, b_opnd};
    // Top bit of the widened difference is set exactly when acc < B (unsigned borrow)
    assign sub_w   = {1'b0, acc_q} - {1'b0, b_opnd};
    assign wr_cond = bus.i_valid & bus.i_wr_acc & ~busy & (bus.i_sel_a != 2'b11);

    // Single-cycle ALU: result, carry, and whether the op writes this cycle (MUL does not)
    always_comb begin
        alu_res = acc_q;
        alu_c   = c_q;
        alu_wr  = 1'b1;
        case (bus.i_alu_op)
            OP_ADD: begin
                alu_res = add_w[NB_DATA-1:0];
                alu_c   = add_w[NB_DATA];
            end
            OP_SUB: begin
                alu_res = sub_w[NB_DATA-1:0];
                alu_c   = sub_w[NB_DATA];
            end
            OP_AND:  alu_res = acc_q & b_opnd;
            OP_OR:   alu_res = acc_q | b_opnd;
            OP_XOR:  alu_res = acc_q ^ b_opnd;
            OP_SHL1: begin
                alu_res = {acc_q[NB_DATA-2:0], 1'b0};
                alu_c   = acc_q[NB_DATA-1];
            end
            OP_SRA1: begin
                alu_res = {acc_q[NB_DATA-1], acc_q[NB_DATA-1:1]};
                alu_c   = acc_q[0];
            end
            default: alu_wr = 1'b0;
        endcase
    end

    // Next-state: accumulator/flag writes, multiplier accept and shift-add iteration
    always_comb begin
        acc_d  = acc_q;
        z_d    = z_q;
        n_d    = n_q;
        c_d    = c_q;
        upd_zn = 1'b0;
`ifdef BIP_DP_MUL_EN
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
`endif
        if (wr_cond) begin
            case (bus.i_sel_a)
                2'b00: begin
                    acc_d  = bus.i_data_mem;
                    upd_zn = 1'b1;
                end
                2'b01: begin
                    acc_d  = ext;
                    upd_zn = 1'b1;
                end
                default: begin
                    // sel_a = 10; 11 never reaches here because wr_cond excludes it
                    if (alu_wr) begin
                        acc_d  = alu_res;
                        c_d    = alu_c;
                        upd_zn = 1'b1;
                    end
`ifdef BIP_DP_MUL_EN
                    else begin
                        // Operands latched unsigned; acc and flags keep their value until the last iteration
                        state_d  = ST_MUL;
                        mcand_d  = {{NB_DATA{1'b0}}, acc_q};
                        mplier_d = b_opnd;
                        prod_d   = '0;
                        cnt_d    = '0;
                    end
`endif
                end
            endcase
        end
`ifdef BIP_DP_MUL_EN
        if (state_q == ST_MUL) begin
            prod_d   = mplier_q[0] ? (prod_q + mcand_q) : prod_q;
            mcand_d  = {mcand_q[2*NB_DATA-2:0], 1'b0};
            mplier_d = {1'b0, mplier_q[NB_DATA-1:1]};
            cnt_d    = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_CNT) begin
                acc_d   = prod_d[NB_DATA-1:0];
                c_d     = |prod_d[2*NB_DATA-1:NB_DATA];
                upd_zn  = 1'b1;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
        end
`endif
        if (upd_zn) begin
            z_d = (acc_d == '0);
            n_d = acc_d[NB_DATA-1];
        end
    end

    // Accumulator and status flag registers
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            acc_q <= '0;
            z_q   <= 1'b0;
            n_q   <= 1'b0;
            c_q   <= 1'b0;
        end else begin
            acc_q <= acc_d;
            z_q   <= z_d;
            n_q   <= n_d;
            c_q   <= c_d;
        end
    end

`ifdef BIP_DP_MUL_EN
    // Multiplier FSM state register; reset aborts any multiply in flight
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Multiplier working registers and the one-cycle done pulse
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
        end
    end

    assign bus.o_done = done_q;
`else
    assign bus.o_done = 1'b0;
`endif

    assign bus.o_data  = acc_q;
    assign bus.o_zero  = z_q;
    assign bus.o_neg   = n_q;
    assign bus.o_carry = c_q;
    assign bus.o_busy  = busy;

endmodule
